// File: rtl/instruction_fetch_queue_pkg.sv
// rtl/instruction_fetch_queue_pkg.sv - shared opcode, instruction and immediate-format types
package instruction_fetch_queue_pkg;

    localparam int LaneBits = 32;

    typedef enum logic [6:0] {
        LoadType   = 7'b0000011,
        Fence      = 7'b0001111,
        AluIType   = 7'b0010011,
        Auipc      = 7'b0010111,
        AluIWType  = 7'b0011011,
        SType      = 7'b0100011,
        AluRType   = 7'b0110011,
        Lui        = 7'b0110111,
        AluRWType  = 7'b0111011,
        BType      = 7'b1100011,
        Jalr       = 7'b1100111,
        Jal        = 7'b1101111,
        SystemType = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        opcode_t    opcode;
    } instruction_t;

    typedef enum logic [2:0] {
        RFormat       = 3'd0,
        IFormat       = 3'd1,
        SFormat       = 3'd2,
        BFormat       = 3'd3,
        UFormat       = 3'd4,
        JFormat       = 3'd5,
        InvalidFormat = 3'd6
    } imm_format_t;

    // Every listed opcode ends in 2'b11, so an unlisted opcode also covers
    // the compressed-encoding case.
    function automatic imm_format_t format_of(logic [6:0] op);
        imm_format_t fmt;
        case (op)
            AluRType, AluRWType:                                 fmt = RFormat;
            AluIType, AluIWType, LoadType, Jalr, Fence, SystemType: fmt = IFormat;
            SType:                                               fmt = SFormat;
            BType:                                               fmt = BFormat;
            Lui, Auipc:                                          fmt = UFormat;
            Jal:                                                 fmt = JFormat;
            default:                                             fmt = InvalidFormat;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_imm_decoder.sv
// rtl/instruction_fetch_queue_imm_decoder.sv - combinational format classifier and immediate extractor
module imm_decoder
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DATA_SIZE = 64
) (
    input  logic [31:0]          instruction,
    output imm_format_t          format,
    output logic [DATA_SIZE-1:0] imm,
    output logic                 illegal
);

    instruction_t inst;
    logic [31:0]  imm32;

    assign inst = instruction;

    always_comb begin
        imm32  = '0;
        format = format_of(inst.opcode);
        case (format)
            IFormat: imm32 = {{20{inst.funct7[6]}}, inst.funct7, inst.rs2};
            SFormat: imm32 = {{20{inst.funct7[6]}}, inst.funct7, inst.rd};
            BFormat: imm32 = {{19{inst.funct7[6]}}, inst.funct7[6], inst.rd[0],
                              inst.funct7[5:0], inst.rd[4:1], 1'b0};
            UFormat: imm32 = {inst.funct7, inst.rs2, inst.rs1, inst.funct3, 12'b0};
            JFormat: imm32 = {{11{inst.funct7[6]}}, inst.funct7[6], inst.rs1, inst.funct3,
                              inst.rs2[0], inst.funct7[5:0], inst.rs2[4:1], 1'b0};
            default: imm32 = '0;
        endcase
        illegal = (format == InvalidFormat);
    end

    // Replication count stays >= 1 so DATA_SIZE = 32 remains legal.
    assign imm = {{(DATA_SIZE - 31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - multi-lane fetch buffer presenting one decoded instruction per cycle
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int FETCH_WIDTH = 64,
    parameter int DEPTH       = 4,
    parameter int DATA_SIZE   = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [FETCH_WIDTH-1:0] fetch_data,
    input  logic [DATA_SIZE-1:0]   fetch_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [31:0]            dec_instruction,
    output logic [DATA_SIZE-1:0]   dec_pc,
    output imm_format_t            dec_format,
    output logic [DATA_SIZE-1:0]   dec_imm,
    output logic                   dec_illegal
);

    localparam int LANES = FETCH_WIDTH / LaneBits;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LaneBits-1:0]  inst_mem [DEPTH];
    logic [DATA_SIZE-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Driven from the registered count only: no combinational path from dec_ready.
    assign fetch_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(LANES);
    assign dec_valid   = (count != '0);
    assign push        = fetch_valid && fetch_ready;
    assign pop         = dec_valid && dec_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(LANES);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (push ? CNT_W'(LANES) : '0) - (pop ? CNT_W'(1) : '0);
        end
    end

    // wr_ptr only ever advances by LANES from zero and DEPTH % LANES == 0,
    // so a beat never straddles the wrap point.
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            for (int i = 0; i < LANES; i++) begin
                inst_mem[wr_ptr + PTR_W'(i)] <= fetch_data[LaneBits*i +: LaneBits];
                pc_mem[wr_ptr + PTR_W'(i)]   <= fetch_pc + DATA_SIZE'(4 * i);
            end
        end
    end

    assign dec_instruction = inst_mem[rd_ptr];
    assign dec_pc          = pc_mem[rd_ptr];

    imm_decoder #(
        .DATA_SIZE (DATA_SIZE)
    ) u_imm_decoder (
        .instruction (dec_instruction),
        .format      (dec_format),
        .imm         (dec_imm),
        .illegal     (dec_illegal)
    );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - self-checking bench for the fetch queue and its immediate decoder
module tb_instruction_fetch_queue;
    import instruction_fetch_queue_pkg::*;

    int checks   = 0;
    int failures = 0;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // default configuration: FETCH_WIDTH=64, DEPTH=4
    logic        reset, flush, fetch_valid, fetch_ready, dec_valid, dec_ready, dec_illegal;
    logic [63:0] fetch_data, fetch_pc, dec_pc, dec_imm;
    logic [31:0] dec_instruction;
    logic [2:0]  dec_format;

    // streaming configuration: FETCH_WIDTH=128, DEPTH=8
    logic         reset_b, flush_b, fetch_valid_b, fetch_ready_b, dec_valid_b, dec_ready_b, dec_illegal_b;
    logic [127:0] fetch_data_b;
    logic [63:0]  fetch_pc_b, dec_pc_b, dec_imm_b;
    logic [31:0]  dec_instruction_b;
    logic [2:0]   dec_format_b;

    // standalone decoder
    logic [31:0] d_inst;
    logic [2:0]  d_fmt;
    logic [63:0] d_imm;
    logic        d_ill;

    instruction_fetch_queue #(.FETCH_WIDTH(64), .DEPTH(4), .DATA_SIZE(64)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_data(fetch_data), .fetch_pc(fetch_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instruction(dec_instruction), .dec_pc(dec_pc),
        .dec_format(dec_format), .dec_imm(dec_imm), .dec_illegal(dec_illegal)
    );

    instruction_fetch_queue #(.FETCH_WIDTH(128), .DEPTH(8), .DATA_SIZE(64)) dut_b (
        .clock(clock), .reset(reset_b), .flush(flush_b),
        .fetch_valid(fetch_valid_b), .fetch_ready(fetch_ready_b),
        .fetch_data(fetch_data_b), .fetch_pc(fetch_pc_b),
        .dec_valid(dec_valid_b), .dec_ready(dec_ready_b),
        .dec_instruction(dec_instruction_b), .dec_pc(dec_pc_b),
        .dec_format(dec_format_b), .dec_imm(dec_imm_b), .dec_illegal(dec_illegal_b)
    );

    imm_decoder #(.DATA_SIZE(64)) u_dec (
        .instruction(d_inst), .format(d_fmt), .imm(d_imm), .illegal(d_ill)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        ill;
    } dvec_t;

    typedef struct {
        logic        flush;
        logic        fv;
        logic [63:0] data;
        logic [63:0] pc;
        logic        rdy;
        logic        ev;
        logic        er;
        logic [63:0] epc;
        logic [31:0] einst;
    } qvec_t;

    function automatic dvec_t dv(logic [31:0] i, imm_format_t f, logic [63:0] m, logic l);
        dvec_t v;
        v.inst = i; v.fmt = f; v.imm = m; v.ill = l;
        return v;
    endfunction

    function automatic qvec_t qv(logic fl, logic fv, logic [63:0] d, logic [63:0] p, logic r,
                                 logic ev, logic er, logic [63:0] epc, logic [31:0] ei);
        qvec_t v;
        v.flush = fl; v.fv = fv; v.data = d; v.pc = p; v.rdy = r;
        v.ev = ev; v.er = er; v.epc = epc; v.einst = ei;
        return v;
    endfunction

    function automatic logic [31:0] stream_word(int beat, int lane);
        return 32'hC000_0000 | (32'(beat) << 2) | 32'(lane);
    endfunction

    dvec_t dtab[18];
    qvec_t qtab[20];

    localparam logic [63:0] BA = 64'h00200113_00100093;
    localparam logic [63:0] BB = 64'h00400213_00300193;
    localparam logic [63:0] BC = 64'h00600313_00500293;
    localparam logic [63:0] BD = 64'h00800413_00700393;
    localparam logic [63:0] BE = 64'h00A00513_00900493;
    localparam logic [63:0] BF = 64'h00C00613_00B00593;
    localparam logic [63:0] BG = 64'h00E00713_00D00693;
    localparam logic [63:0] BH = 64'h01000813_00F00793;
    localparam logic [63:0] BJ = 64'h01200913_01100893;

    initial begin
        int pushed, popped, cyc;

        dtab[0]  = dv(32'hFFF00093, IFormat,       64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        dtab[1]  = dv(32'h008000EF, JFormat,       64'h0000_0000_0000_0008, 1'b0);
        dtab[2]  = dv(32'hFE20AE23, SFormat,       64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        dtab[3]  = dv(32'h123452B7, UFormat,       64'h0000_0000_1234_5000, 1'b0);
        dtab[4]  = dv(32'hFE000CE3, BFormat,       64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        dtab[5]  = dv(32'h002081B3, RFormat,       64'h0,                   1'b0);
        dtab[6]  = dv(32'h002081BB, RFormat,       64'h0,                   1'b0);
        dtab[7]  = dv(32'h800000B7, UFormat,       64'hFFFF_FFFF_8000_0000, 1'b0);
        dtab[8]  = dv(32'h80008067, IFormat,       64'hFFFF_FFFF_FFFF_F800, 1'b0);
        dtab[9]  = dv(32'h01012283, IFormat,       64'h10,                  1'b0);
        dtab[10] = dv(32'h0FF0000F, IFormat,       64'hFF,                  1'b0);
        dtab[11] = dv(32'h00000073, IFormat,       64'h0,                   1'b0);
        dtab[12] = dv(32'h00001017, UFormat,       64'h1000,                1'b0);
        dtab[13] = dv(32'h0010009B, IFormat,       64'h1,                   1'b0);
        dtab[14] = dv(32'hFFDFF06F, JFormat,       64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        dtab[15] = dv(32'h00000000, InvalidFormat, 64'h0,                   1'b1);
        dtab[16] = dv(32'hFFFFFFFF, InvalidFormat, 64'h0,                   1'b1);
        dtab[17] = dv(32'hFFF00012, InvalidFormat, 64'h0,                   1'b1);

        //            flush fv   data pc          rdy   ev    er    epc         einst
        qtab[0]  = qv(1'b0, 1'b1, BA, 64'h100, 1'b0, 1'b0, 1'b1, 64'h0,   32'h0);
        qtab[1]  = qv(1'b0, 1'b1, BB, 64'h108, 1'b0, 1'b1, 1'b1, 64'h100, 32'h00100093);
        qtab[2]  = qv(1'b0, 1'b1, BC, 64'h110, 1'b0, 1'b1, 1'b0, 64'h100, 32'h00100093);
        qtab[3]  = qv(1'b0, 1'b0, BC, 64'h110, 1'b1, 1'b1, 1'b0, 64'h100, 32'h00100093);
        qtab[4]  = qv(1'b0, 1'b0, BC, 64'h110, 1'b1, 1'b1, 1'b0, 64'h104, 32'h00200113);
        qtab[5]  = qv(1'b0, 1'b1, BC, 64'h110, 1'b0, 1'b1, 1'b1, 64'h108, 32'h00300193);
        qtab[6]  = qv(1'b0, 1'b1, BD, 64'h118, 1'b1, 1'b1, 1'b0, 64'h108, 32'h00300193);
        qtab[7]  = qv(1'b0, 1'b1, BD, 64'h118, 1'b1, 1'b1, 1'b0, 64'h10C, 32'h00400213);
        qtab[8]  = qv(1'b0, 1'b1, BD, 64'h118, 1'b1, 1'b1, 1'b1, 64'h110, 32'h00500293);
        qtab[9]  = qv(1'b0, 1'b0, BD, 64'h118, 1'b1, 1'b1, 1'b0, 64'h114, 32'h00600313);
        qtab[10] = qv(1'b0, 1'b0, BD, 64'h118, 1'b1, 1'b1, 1'b1, 64'h118, 32'h00700393);
        qtab[11] = qv(1'b1, 1'b1, BE, 64'h120, 1'b1, 1'b1, 1'b1, 64'h11C, 32'h00800413);
        qtab[12] = qv(1'b0, 1'b0, BE, 64'h120, 1'b1, 1'b0, 1'b1, 64'h0,   32'h0);
        qtab[13] = qv(1'b0, 1'b1, BF, 64'h200, 1'b0, 1'b0, 1'b1, 64'h0,   32'h0);
        qtab[14] = qv(1'b0, 1'b1, BG, 64'h208, 1'b0, 1'b1, 1'b1, 64'h200, 32'h00B00593);
        qtab[15] = qv(1'b1, 1'b1, BH, 64'h300, 1'b1, 1'b1, 1'b0, 64'h200, 32'h00B00593);
        qtab[16] = qv(1'b0, 1'b0, BH, 64'h300, 1'b0, 1'b0, 1'b1, 64'h0,   32'h0);
        qtab[17] = qv(1'b0, 1'b1, BJ, 64'h400, 1'b1, 1'b0, 1'b1, 64'h0,   32'h0);
        qtab[18] = qv(1'b0, 1'b0, BJ, 64'h400, 1'b0, 1'b1, 1'b1, 64'h400, 32'h01100893);
        qtab[19] = qv(1'b0, 1'b0, BJ, 64'h400, 1'b0, 1'b1, 1'b1, 64'h400, 32'h01100893);

        reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0; fetch_pc = '0; dec_ready = 1'b0;
        reset_b = 1'b1; flush_b = 1'b0; fetch_valid_b = 1'b0; fetch_data_b = '0; fetch_pc_b = '0; dec_ready_b = 1'b1;
        d_inst = '0;

        for (int i = 0; i < 18; i++) begin
            d_inst = dtab[i].inst;
            #1;
            check($sformatf("dec%0d_fmt", i),     64'(d_fmt), 64'(dtab[i].fmt));
            check($sformatf("dec%0d_imm", i),     d_imm,      dtab[i].imm);
            check($sformatf("dec%0d_illegal", i), 64'(d_ill), 64'(dtab[i].ill));
        end

        step(); step();
        reset = 1'b0; reset_b = 1'b0;
        check("reset_dec_valid",   64'(dec_valid),   64'd0);
        check("reset_fetch_ready", 64'(fetch_ready), 64'd1);

        fetch_valid = 1'b1; fetch_data = 64'h008000EF_FFF00093; fetch_pc = 64'h1000;
        step();
        fetch_valid = 1'b0;
        check("beat1_valid",   64'(dec_valid),       64'd1);
        check("beat1_pc0",     dec_pc,               64'h1000);
        check("beat1_inst0",   64'(dec_instruction), 64'hFFF00093);
        check("beat1_fmt0",    64'(dec_format),      64'(IFormat));
        check("beat1_imm0",    dec_imm,              64'hFFFF_FFFF_FFFF_FFFF);
        dec_ready = 1'b1; step(); dec_ready = 1'b0;
        check("beat1_pc1",     dec_pc,               64'h1004);
        check("beat1_fmt1",    64'(dec_format),      64'(JFormat));
        check("beat1_imm1",    dec_imm,              64'h8);
        dec_ready = 1'b1; step(); dec_ready = 1'b0;
        check("beat1_drained", 64'(dec_valid),       64'd0);

        fetch_valid = 1'b1; fetch_data = 64'h123452B7_FE20AE23; fetch_pc = 64'h2000;
        step();
        fetch_valid = 1'b0;
        check("beat2_fmt0", 64'(dec_format), 64'(SFormat));
        check("beat2_imm0", dec_imm,         64'hFFFF_FFFF_FFFF_FFFC);
        dec_ready = 1'b1; step();
        check("beat2_pc1",  dec_pc,          64'h2004);
        check("beat2_fmt1", 64'(dec_format), 64'(UFormat));
        check("beat2_imm1", dec_imm,         64'h0000_0000_1234_5000);
        step(); dec_ready = 1'b0;
        check("beat2_drained", 64'(dec_valid), 64'd0);

        // illegal lanes, with lane 1 PC wrapping past 2^64
        fetch_valid = 1'b1; fetch_data = 64'hFFFFFFFF_00000000; fetch_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        fetch_valid = 1'b0;
        check("ill0_illegal", 64'(dec_illegal), 64'd1);
        check("ill0_fmt",     64'(dec_format),  64'(InvalidFormat));
        check("ill0_imm",     dec_imm,          64'h0);
        check("ill0_pc",      dec_pc,           64'hFFFF_FFFF_FFFF_FFFC);
        dec_ready = 1'b1; step();
        check("ill1_illegal", 64'(dec_illegal), 64'd1);
        check("ill1_imm",     dec_imm,          64'h0);
        check("ill1_pc",      dec_pc,           64'h0);
        step(); dec_ready = 1'b0;
        check("ill_drained",  64'(dec_valid),   64'd0);

        for (int r = 0; r < 20; r++) begin
            flush = qtab[r].flush; fetch_valid = qtab[r].fv; fetch_data = qtab[r].data;
            fetch_pc = qtab[r].pc; dec_ready = qtab[r].rdy;
            check($sformatf("row%0d_dec_valid", r),   64'(dec_valid),   64'(qtab[r].ev));
            check($sformatf("row%0d_fetch_ready", r), 64'(fetch_ready), 64'(qtab[r].er));
            if (qtab[r].ev) begin
                check($sformatf("row%0d_pc", r),   dec_pc,               qtab[r].epc);
                check($sformatf("row%0d_inst", r), 64'(dec_instruction), 64'(qtab[r].einst));
            end
            step();
        end
        flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;

        // reset mid-operation with a concurrent beat and pop
        reset = 1'b1; fetch_valid = 1'b1; fetch_data = BA; dec_ready = 1'b1;
        step();
        reset = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
        check("midreset_valid", 64'(dec_valid),   64'd0);
        check("midreset_ready", 64'(fetch_ready), 64'd1);

        pushed = 0; popped = 0; cyc = 0;
        while ((pushed < 100 || popped < 400) && cyc < 3000) begin
            fetch_valid_b = fetch_ready_b && (pushed < 100);
            for (int l = 0; l < 4; l++) fetch_data_b[32*l +: 32] = stream_word(pushed, l);
            fetch_pc_b = 64'h8000 + 64'(16 * pushed);
            if (dec_valid_b) begin
                check("stream_inst", 64'(dec_instruction_b), 64'(stream_word(popped / 4, popped % 4)));
                check("stream_pc",   dec_pc_b,               64'h8000 + 64'(4 * popped));
                popped++;
            end
            if (fetch_valid_b) pushed++;
            step();
            cyc++;
        end
        fetch_valid_b = 1'b0;
        check("stream_pushed",  64'(pushed),      64'd100);
        check("stream_popped",  64'(popped),      64'd400);
        check("stream_leftover", 64'(dec_valid_b), 64'd0);

        for (int c = 0; c < 5; c++) begin
            fetch_valid_b = fetch_ready_b;
            fetch_data_b = {4{stream_word(c, 0)}};
            step();
        end
        reset_b = 1'b1; fetch_valid_b = 1'b1;
        step();
        reset_b = 1'b0; fetch_valid_b = 1'b0;
        check("stream_reset_valid", 64'(dec_valid_b),   64'd0);
        check("stream_reset_ready", 64'(fetch_ready_b), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Parametrised fetch-to-decode buffer: accepts fetch words of LANES = FETCH_WIDTH/32 RV instructions per beat, queues them with their PCs, and presents one instruction per cycle to decode.
- Each presented instruction carries its instruction_t view, format class, sign-extended immediate and an illegal flag.
- Sits between the instruction memory interface and the control/datapath decode stage.
- Supports multi-lane fetch, configurable depth, and flush on redirect.

Parameters:
FETCH_WIDTH, 64, fetch beat width in bits; multiple of 32; LANES = FETCH_WIDTH/32.
DEPTH, 4, queue entries (one instruction each); power of 2; DEPTH >= LANES and DEPTH % LANES == 0.
DATA_SIZE, 64, PC and immediate width; 32 or 64.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  discard all queued entries (branch/trap redirect).
fetch_valid  input  1  fetch beat valid.
fetch_ready  output  1  queue has >= LANES free entries.
fetch_data  input  FETCH_WIDTH  lane i = fetch_data[32*i+31:32*i].
fetch_pc  input  DATA_SIZE  PC of lane 0; lane i PC = fetch_pc + 4*i (modulo 2^DATA_SIZE).
dec_valid  output  1  head entry valid.
dec_ready  input  1  decode consumes head.
dec_instruction  output  32  head instruction, instruction_t layout.
dec_pc  output  DATA_SIZE  head PC.
dec_format  output  3  imm_format_t of head.
dec_imm  output  DATA_SIZE  decoded, sign-extended immediate.
dec_illegal  output  1  head opcode not in opcode_t, or inst[1:0] != 2'b11.

Behaviour:
- Storage: circular buffer of DEPTH {instruction, pc}; read/write pointers of log2(DEPTH) bits, wrap naturally; count of log2(DEPTH)+1 bits.
- Reset: pointers and count = 0. Outputs after reset: dec_valid=0, fetch_ready=1; dec_* data outputs are don't-care but must not be X-propagating to dec_valid.
- Push: fetch_valid && fetch_ready writes all LANES lanes in lane order at the write pointer; count += LANES.
- Pop: dec_valid && dec_ready advances the read pointer; count -= 1.
- Simultaneous push and pop: count += LANES-1.
- fetch_ready = (DEPTH - count) >= LANES, computed from registered count only. It is not combinationally dependent on dec_ready, so no bypass.
- Latency: an instruction pushed at edge N is visible on dec_* after edge N (one cycle). No same-cycle fetch-to-decode bypass.
- dec_valid = (count != 0). dec_* are combinational decodes of the head entry.
- Full (count == DEPTH): fetch_ready=0 and fetch_valid is ignored.
- Empty: dec_valid=0 and dec_ready is ignored.
- Flush: has priority over push and pop in the same cycle. Pointers and count are cleared; a concurrent fetch beat and pop are both discarded. Next cycle: dec_valid=0, fetch_ready=1.
- Reset asserted mid-operation is equivalent to flush plus initial state.
- Format by opcode:
  - AluRType, AluRWType -> R.
  - AluIType, AluIWType, LoadType, Jalr, Fence, SystemType -> I.
  - SType -> S; BType -> B; Lui, Auipc -> U; Jal -> J.
  - Anything else -> Invalid, with dec_illegal=1 and dec_imm=0.
- Immediates (bit indices into inst; result sign-extended from inst[31] to DATA_SIZE):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R: 0.
- dec_illegal is informational only; illegal entries still pop normally.

Decomposition:
- Shared package: add imm_format_t enum (RFormat=0, IFormat, SFormat, BFormat, UFormat, JFormat, InvalidFormat) and a LaneBits=32 constant. Reuse opcode_t and instruction_t unchanged.
- Sub-module imm_decoder: combinational; 32-bit instruction in, imm_format_t, DATA_SIZE immediate and illegal out; parameter DATA_SIZE. Verified standalone.

Test Plan:
- Reset, then one beat with fetch_data={0x008000EF, 0xFFF00093} at fetch_pc=0x1000 (defaults) -> next cycle dec_pc=0x1000, IFormat, dec_imm=0xFFFF_FFFF_FFFF_FFFF; after pop, dec_pc=0x1004, JFormat, dec_imm=8.
- Lanes 0xFE20AE23 (sw x2,-4(x1)) and 0x123452B7 (lui x5,0x12345) -> SFormat with dec_imm=0xFFFF_FFFF_FFFF_FFFC, then UFormat with dec_imm=0x0000_0000_1234_5000.
- Two beats with dec_ready=0 -> count=4, fetch_ready=0, third beat ignored. Then dec_ready=1 for 2 cycles -> fetch_ready=1; drained order and PCs match push order, including pointer wrap.
- Full queue; flush asserted together with fetch_valid and dec_ready -> next cycle dec_valid=0, fetch_ready=1, nothing from the flushed beat appears.
- Lane word 0x00000000 and word with opcode 0x7F -> dec_illegal=1, InvalidFormat, dec_imm=0; both pop normally.
- Steady streaming with dec_ready=1, DEPTH=8 and FETCH_WIDTH=128 -> no lost or duplicated entry over 100 beats, checked against a scoreboard. Apply reset mid-stream -> dec_valid=0 next cycle.
